// File: rtl/outpass4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : outpass4_pkg
// Description : Shared lane width, arbiter state encoding and default idle
//               lane value for the OutPass4 round-robin lane arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package outpass4_pkg;

    // Width of the OutPass4_frame_config lane (I0..I3)
    localparam int LANE_W = 4;

    // Value presented on the lane while no grant is active
    localparam logic [LANE_W-1:0] DEFAULT_IDLE_VALUE = 4'h0;

    // Arbiter states: IDLE = lane free, DRIVE = a granted word is on the lane
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/outpass4_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : outpass4_rr_arbiter_rr_pick
// Description : Combinational rotating-priority encoder. Returns the first
//               unmasked requester found when scanning upward from the
//               round-robin pointer, wrapping modulo NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module outpass4_rr_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [NUM_REQ-1:0] i_mask,
    input  logic [SRC_W-1:0]   i_rr_ptr,
    output logic               o_any,
    output logic [SRC_W-1:0]   o_sel
);

    logic [NUM_REQ-1:0] w_cand;
    logic [NUM_REQ-1:0] w_rot;
    logic [SRC_W:0]     w_off;
    logic [SRC_W:0]     w_sum;

    // The requester currently being acked may not win this cycle
    assign w_cand = i_req & ~i_mask;

    // Rotate so that bit 0 corresponds to the pointer position; the doubled
    // copy supplies the wrapped-around entries without any modulo logic
    assign w_rot = NUM_REQ'({w_cand, w_cand} >> i_rr_ptr);

    assign o_any = |w_rot;

    // Lowest set bit of the rotated vector is the distance from the pointer
    always_comb begin
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = (SRC_W + 1)'(k);
            end
        end
    end

    // Map distance back to an absolute index; a single subtract suffices
    // because pointer and distance are both below NUM_REQ
    assign w_sum = {1'b0, i_rr_ptr} + w_off;
    assign o_sel = (w_sum >= (SRC_W + 1)'(NUM_REQ))
                 ? SRC_W'(w_sum - (SRC_W + 1)'(NUM_REQ))
                 : w_sum[SRC_W-1:0];

endmodule
`default_nettype wire

// File: rtl/outpass4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : outpass4_rr_arbiter
// Description : Shares one 4-bit OutPass4 output lane between NUM_REQ fabric
//               requesters. Grants round-robin, freezes the granted word on
//               the lane for HOLD_CYCLES cycles and pulses a one-cycle ack in
//               the final drive cycle. Back-to-back grants leave no gap.
// Revision    : 1.0 - initial release
// ============================================================================
module outpass4_rr_arbiter
    import outpass4_pkg::*;
#(
    parameter int                NUM_REQ     = 4,
    parameter int                HOLD_CYCLES = 2,
    parameter logic [LANE_W-1:0] IDLE_VALUE  = DEFAULT_IDLE_VALUE
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*LANE_W-1:0]  data,
    output logic [NUM_REQ-1:0]         ack,
    output logic [LANE_W-1:0]          out_data,
    output logic                       out_valid,
    output logic [$clog2(NUM_REQ)-1:0] out_src
);

    localparam int c_SRC_W  = $clog2(NUM_REQ);
    localparam int c_HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [c_SRC_W-1:0]  c_LAST_IDX  = c_SRC_W'(NUM_REQ - 1);

    arb_state_e          r_state;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [c_SRC_W-1:0]  r_rr_ptr;
    logic [LANE_W-1:0]   r_out_data;
    logic                r_out_valid;
    logic [c_SRC_W-1:0]  r_out_src;
    logic [NUM_REQ-1:0]  r_ack;

    logic [c_SRC_W-1:0]  w_next_ptr;
    logic [c_SRC_W-1:0]  w_scan_ptr;
    logic                w_any;
    logic [c_SRC_W-1:0]  w_sel;
    logic [LANE_W-1:0]   w_sel_data;
    logic [NUM_REQ-1:0]  w_sel_onehot;
    logic [NUM_REQ-1:0]  w_src_onehot;

    // Pointer value that takes effect once the current grant finishes
    assign w_next_ptr = (r_out_src == c_LAST_IDX) ? '0 : r_out_src + c_SRC_W'(1);

    // During DRIVE the only scan that matters is in the final cycle, where
    // the next grant must already start after the current grantee
    assign w_scan_ptr = (r_state == DRIVE) ? w_next_ptr : r_rr_ptr;

    // ack is high exactly in the final cycle, so it doubles as the mask
    outpass4_rr_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .SRC_W   (c_SRC_W)
    ) u_rr_pick (
        .i_req    (req),
        .i_mask   (r_ack),
        .i_rr_ptr (w_scan_ptr),
        .o_any    (w_any),
        .o_sel    (w_sel)
    );

    // Word of the selected requester, picked with constant slices
    always_comb begin
        w_sel_data = IDLE_VALUE;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel == c_SRC_W'(i)) begin
                w_sel_data = data[i*LANE_W +: LANE_W];
            end
        end
    end

    assign w_sel_onehot = NUM_REQ'(1) << w_sel;
    assign w_src_onehot = NUM_REQ'(1) << r_out_src;

    // Arbiter FSM, hold counter, lane registers and ack generation
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_hold_cnt  <= '0;
            r_rr_ptr    <= '0;
            r_out_data  <= IDLE_VALUE;
            r_out_valid <= 1'b0;
            r_out_src   <= '0;
            r_ack       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state     <= DRIVE;
                        r_out_data  <= w_sel_data;
                        r_out_src   <= w_sel;
                        r_out_valid <= 1'b1;
                        r_hold_cnt  <= c_HOLD_LOAD;
                        // A single-cycle hold makes the grant cycle the ack cycle
                        r_ack       <= (HOLD_CYCLES == 1) ? w_sel_onehot : '0;
                    end else begin
                        r_ack <= '0;
                    end
                end

                DRIVE: begin
                    if (r_hold_cnt != '0) begin
                        r_hold_cnt <= r_hold_cnt - c_HOLD_W'(1);
                        r_ack      <= (r_hold_cnt == c_HOLD_W'(1)) ? w_src_onehot : '0;
                    end else begin
                        // Final drive cycle ends here
                        r_rr_ptr <= w_next_ptr;
                        if (w_any) begin
                            r_out_data  <= w_sel_data;
                            r_out_src   <= w_sel;
                            r_out_valid <= 1'b1;
                            r_hold_cnt  <= c_HOLD_LOAD;
                            r_ack       <= (HOLD_CYCLES == 1) ? w_sel_onehot : '0;
                        end else begin
                            r_state     <= IDLE;
                            r_out_data  <= IDLE_VALUE;
                            r_out_valid <= 1'b0;
                            r_hold_cnt  <= '0;
                            r_ack       <= '0;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ack       = r_ack;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_src   = r_out_src;

endmodule
`default_nettype wire
